// File: rtl/demux_16_scan_sequencer.sv
// demux_16_scan_sequencer
// Upstream driver for a 1:16 DEMUX. A 16-bit word is accepted over a
// valid/ready handshake, then each channel in scan order is presented on
// Select_Out/Data_Out with Enable_Out high for HOLD_CYCLES cycles. A
// one-cycle Done_Out pulse closes a normally completed scan; Abort_In
// drops the scan with no pulse.
// Optional build macro DEMUX_SCAN_MASK_EN adds Mask_In: masked-off
// channels are skipped in zero cycles, and an all-zero mask completes
// immediately without entering SCAN.
module demux_16_scan_sequencer #(
  parameter int HOLD_CYCLES = 1,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic        Clock_In,
  input  logic        Reset_In,
  input  logic        Valid_In,
  input  logic [15:0] Word_In,
`ifdef DEMUX_SCAN_MASK_EN
  input  logic [15:0] Mask_In,
`endif
  output logic        Ready_Out,
  input  logic        Abort_In,
  output logic        Enable_Out,
  output logic        Data_Out,
  output logic [3:0]  Select_Out,
  output logic        Busy_Out,
  output logic        Done_Out
);

  // Last value of the 8-bit hold counter before stepping to the next channel.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state;
  logic [15:0] word_reg;
  logic [15:0] mask_reg;
  logic [15:0] accept_mask;
  logic [7:0]  hold_cnt;
  logic [3:0]  pos_reg;
  logic [4:0]  first_hit;
  logic [4:0]  next_hit;
  logic [3:0]  first_ch;
  logic [3:0]  next_ch;

  // Scan position (0 = first visited) to DEMUX channel index.
  function automatic logic [3:0] chan_of(input logic [3:0] pos);
    return LSB_FIRST ? pos : (4'd15 - pos);
  endfunction

  // Lowest scan position >= start whose channel is enabled; MSB flags a hit.
  // A start of 16 means the scan has passed the last position.
  function automatic logic [4:0] find_enabled(input logic [15:0] mask,
                                              input logic [4:0]  start);
    logic [4:0] hit;
    hit = 5'd0;
    for (int p = 15; p >= 0; p--) begin
      if ((5'(p) >= start) && mask[chan_of(4'(p))]) begin
        hit = {1'b1, 4'(p)};
      end
    end
    return hit;
  endfunction

`ifdef DEMUX_SCAN_MASK_EN
  assign accept_mask = Mask_In;
`else
  assign accept_mask = 16'hFFFF;
`endif

  // Locate the first channel of a new word and the successor of the current one.
  always_comb begin
    first_hit = find_enabled(accept_mask, 5'd0);
    next_hit  = find_enabled(mask_reg, {1'b0, pos_reg} + 5'd1);
    first_ch  = chan_of(first_hit[3:0]);
    next_ch   = chan_of(next_hit[3:0]);
  end

  // Scan state machine with all outputs registered.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state      <= IDLE;
      Ready_Out  <= 1'b1;
      Enable_Out <= 1'b0;
      Data_Out   <= 1'b0;
      Select_Out <= 4'd0;
      Busy_Out   <= 1'b0;
      Done_Out   <= 1'b0;
      word_reg   <= 16'd0;
      mask_reg   <= 16'd0;
      hold_cnt   <= 8'd0;
      pos_reg    <= 4'd0;
    end else begin
      Done_Out <= 1'b0;
      case (state)
        IDLE: begin
          if (Valid_In && Ready_Out) begin
            word_reg <= Word_In;
            mask_reg <= accept_mask;
            hold_cnt <= 8'd0;
            if (first_hit[4]) begin
              state      <= SCAN;
              pos_reg    <= first_hit[3:0];
              Select_Out <= first_ch;
              Data_Out   <= Word_In[first_ch];
              Enable_Out <= 1'b1;
              Busy_Out   <= 1'b1;
              Ready_Out  <= 1'b0;
            end else begin
              // Nothing enabled: report completion straight away.
              Done_Out <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (Abort_In) begin
            state      <= IDLE;
            Ready_Out  <= 1'b1;
            Enable_Out <= 1'b0;
            Data_Out   <= 1'b0;
            Select_Out <= 4'd0;
            Busy_Out   <= 1'b0;
            word_reg   <= 16'd0;
            mask_reg   <= 16'd0;
            hold_cnt   <= 8'd0;
            pos_reg    <= 4'd0;
          end else if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= 8'd0;
            if (next_hit[4]) begin
              pos_reg    <= next_hit[3:0];
              Select_Out <= next_ch;
              Data_Out   <= word_reg[next_ch];
            end else begin
              state      <= IDLE;
              Ready_Out  <= 1'b1;
              Enable_Out <= 1'b0;
              Data_Out   <= 1'b0;
              Select_Out <= 4'd0;
              Busy_Out   <= 1'b0;
              Done_Out   <= 1'b1;
              pos_reg    <= 4'd0;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_16_scan_sequencer.sv
// Testbench for demux_16_scan_sequencer: two instances (HOLD=1 LSB-first and
// HOLD=3 MSB-first) driven by directed vectors, checked every cycle against a
// queue-based expected-output model plus hand-computed literal expectations.
module tb_demux_16_scan_sequencer;

  localparam int HA = 1;
  localparam bit LA = 1'b1;
  localparam int HB = 3;
  localparam bit LB = 1'b0;

  typedef struct packed {
    logic       en;
    logic       data;
    logic [3:0] sel;
    logic       ready;
    logic       busy;
    logic       done;
  } exp_t;

  localparam exp_t IDLE_EXP = '{en: 1'b0, data: 1'b0, sel: 4'd0, ready: 1'b1, busy: 1'b0, done: 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  valid;
  logic [1:0]  abort;
  logic [15:0] word [2];
  logic [15:0] mask [2];
  logic [1:0]  ready, en, data, busy, done;
  logic [3:0]  sel [2];

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t m_cur;

  always #5 clk = ~clk;

  demux_16_scan_sequencer #(.HOLD_CYCLES(HA), .LSB_FIRST(LA)) dut_a (
    .Clock_In(clk), .Reset_In(rst), .Valid_In(valid[0]), .Word_In(word[0]),
`ifdef DEMUX_SCAN_MASK_EN
    .Mask_In(mask[0]),
`endif
    .Ready_Out(ready[0]), .Abort_In(abort[0]), .Enable_Out(en[0]),
    .Data_Out(data[0]), .Select_Out(sel[0]), .Busy_Out(busy[0]), .Done_Out(done[0])
  );

  demux_16_scan_sequencer #(.HOLD_CYCLES(HB), .LSB_FIRST(LB)) dut_b (
    .Clock_In(clk), .Reset_In(rst), .Valid_In(valid[1]), .Word_In(word[1]),
`ifdef DEMUX_SCAN_MASK_EN
    .Mask_In(mask[1]),
`endif
    .Ready_Out(ready[1]), .Abort_In(abort[1]), .Enable_Out(en[1]),
    .Data_Out(data[1]), .Select_Out(sel[1]), .Busy_Out(busy[1]), .Done_Out(done[1])
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t front(input int i);
    if (i == 0) return (q0.size() > 0) ? q0[0] : IDLE_EXP;
    return (q1.size() > 0) ? q1[0] : IDLE_EXP;
  endfunction

  function automatic void push_e(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  // Expected output sequence for one accepted word: each enabled channel in
  // scan order for HOLD cycles, then a single done cycle.
  function automatic void push_word(input int i, input logic [15:0] w, input logic [15:0] m);
    int  h;
    bit  lsb;
    int  ch;
    exp_t e;
    h   = (i == 0) ? HA : HB;
    lsb = (i == 0) ? LA : LB;
    for (int k = 0; k < 16; k++) begin
      ch = lsb ? k : 15 - k;
      if (m[ch]) begin
        e = '{en: 1'b1, data: w[ch], sel: 4'(ch), ready: 1'b0, busy: 1'b1, done: 1'b0};
        for (int r = 0; r < h; r++) push_e(i, e);
      end
    end
    e = '{en: 1'b0, data: 1'b0, sel: 4'd0, ready: 1'b1, busy: 1'b0, done: 1'b1};
    push_e(i, e);
  endfunction

  function automatic logic [15:0] mask_of(input int i);
`ifdef DEMUX_SCAN_MASK_EN
    return mask[i];
`else
    return (i == 0) ? 16'hFFFF : 16'hFFFF;
`endif
  endfunction

  // Reference model: advance the expected-output queues on each rising edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_cur = front(i);
      if (rst) begin
        if (i == 0) q0.delete(); else q1.delete();
      end else begin
        if (m_cur.busy && abort[i]) begin
          if (i == 0) q0.delete(); else q1.delete();
        end else if (i == 0 && q0.size() > 0) begin
          void'(q0.pop_front());
        end else if (i == 1 && q1.size() > 0) begin
          void'(q1.pop_front());
        end
        if (m_cur.ready && valid[i]) push_word(i, word[i], mask_of(i));
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_inst%0d {en,data,sel,ready,busy,done}", i),
            {7'd0, en[i], data[i], sel[i], ready[i], busy[i], done[i]},
            {7'd0, front(i)});
      end
    end
  end

  // Present a word at a falling edge; returns at the first cycle after accept.
  task automatic accept_word(input int i, input logic [15:0] w, input logic [15:0] m);
    @(negedge clk);
    valid[i] = 1'b1;
    word[i]  = w;
    mask[i]  = m;
    @(negedge clk);
    valid[i] = 1'b0;
  endtask

  int exp_a [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

  initial begin
    rst = 1'b1;
    valid = 2'b00;
    abort = 2'b00;
    word[0] = 16'd0; word[1] = 16'd0;
    mask[0] = 16'hFFFF; mask[1] = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_ready%0d", i), ready[i], 1);
      chk($sformatf("reset_en%0d", i), en[i], 0);
      chk($sformatf("reset_sel%0d", i), sel[i], 0);
      chk($sformatf("reset_done%0d", i), done[i], 0);
    end

    // HOLD=1, LSB first, word A5C3.
    accept_word(0, 16'hA5C3, 16'hFFFF);
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= 16) begin
        chk($sformatf("a_sel_c%0d", c), sel[0], 16'(c - 1));
        chk($sformatf("a_data_c%0d", c), data[0], 16'(exp_a[c - 1]));
        chk($sformatf("a_done_c%0d", c), done[0], 0);
      end else begin
        chk("a_done_c17", done[0], 1);
        chk("a_en_c17", en[0], 0);
      end
    end

    // HOLD=3, MSB first, word 8001.
    accept_word(1, 16'h8001, 16'hFFFF);
    for (int c = 1; c <= 49; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= 48) begin
        chk($sformatf("b_sel_c%0d", c), sel[1], 16'(15 - (c - 1) / 3));
        chk($sformatf("b_data_c%0d", c), data[1], (c <= 3 || c >= 46) ? 16'd1 : 16'd0);
        chk($sformatf("b_done_c%0d", c), done[1], 0);
      end else begin
        chk("b_done_c49", done[1], 1);
      end
    end

    // Back-to-back with Valid held high; Word_In changes during the first scan.
    @(negedge clk);
    valid[0] = 1'b1;
    word[0]  = 16'hFFFF;
    @(negedge clk);
    word[0] = 16'h0000;
    chk("b2b_first_data", data[0], 1);
    repeat (16) @(negedge clk);
    chk("b2b_done", done[0], 1);
    chk("b2b_ready_on_done", ready[0], 1);
    @(negedge clk);
    chk("b2b_second_en", en[0], 1);
    chk("b2b_second_sel", sel[0], 0);
    chk("b2b_second_data", data[0], 0);
    valid[0] = 1'b0;
    repeat (16) @(negedge clk);
    chk("b2b_second_done", done[0], 1);

    // Abort at channel 7.
    accept_word(0, 16'hA5C3, 16'hFFFF);
    repeat (7) @(negedge clk);
    chk("abort_sel7", sel[0], 7);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort_en", en[0], 0);
    chk("abort_ready", ready[0], 1);
    chk("abort_busy", busy[0], 0);
    for (int c = 0; c < 12; c++) begin
      chk("abort_no_done", done[0], 0);
      @(negedge clk);
    end

    // Abort on the last hold cycle of the last channel.
    accept_word(0, 16'hFFFF, 16'hFFFF);
    repeat (15) @(negedge clk);
    chk("abort_last_sel15", sel[0], 15);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort_last_no_done", done[0], 0);
    chk("abort_last_ready", ready[0], 1);

    // Abort is ignored in IDLE: accept still happens.
    @(negedge clk);
    valid[0] = 1'b1;
    abort[0] = 1'b1;
    word[0]  = 16'h0001;
    @(negedge clk);
    valid[0] = 1'b0;
    abort[0] = 1'b0;
    chk("idle_abort_en", en[0], 1);
    chk("idle_abort_data", data[0], 1);
    repeat (16) @(negedge clk);
    chk("idle_abort_done", done[0], 1);

    // Reset in the middle of a scan.
    accept_word(1, 16'hFFFF, 16'hFFFF);
    repeat (9) @(negedge clk);
    chk("rst_mid_busy", busy[1], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_en", en[1], 0);
    chk("rst_mid_ready", ready[1], 1);
    chk("rst_mid_done", done[1], 0);
    chk("rst_mid_sel", sel[1], 0);
    repeat (50) @(negedge clk);

`ifdef DEMUX_SCAN_MASK_EN
    // Only channels 0 and 2 enabled.
    accept_word(0, 16'h0004, 16'h0005);
    chk("mask_c1_sel", sel[0], 0);
    chk("mask_c1_data", data[0], 0);
    chk("mask_c1_en", en[0], 1);
    @(negedge clk);
    chk("mask_c2_sel", sel[0], 2);
    chk("mask_c2_data", data[0], 1);
    @(negedge clk);
    chk("mask_c3_done", done[0], 1);

    // Empty mask: done on the cycle after accept, never enabled.
    accept_word(0, 16'hFFFF, 16'h0000);
    chk("mask0_done", done[0], 1);
    chk("mask0_en", en[0], 0);
    @(negedge clk);
    chk("mask0_en_after", en[0], 0);
    chk("mask0_done_after", done[0], 0);
    repeat (4) @(negedge clk);
`endif

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
